// File: rtl/nicnac16_bus_pkg.sv
// Shared definitions for the nicnac16 datapath bus: arbiter state encoding,
// requester indices and bus width.
package nicnac16_bus_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  localparam int REQ_A = 0;
  localparam int REQ_B = 1;
  localparam int REQ_C = 2;
  localparam int REQ_D = 3;

  localparam int BUS_W = 16;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/bus_arbiter4_16_rr_pick4.sv
// Rotating-priority picker: first set request bit searching from ptr upward,
// wrapping modulo 4.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       valid,
  output logic [1:0] idx
);

  logic [1:0] cand;

  // Walk the search order backwards so the lowest offset from ptr wins last.
  always_comb begin
    valid = |req;
    idx   = ptr;
    cand  = ptr;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr + 2'(i);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/bus_arbiter4_16.sv
// Round-robin arbiter driving the one-hot select of the 16-bit datapath bus mux.
// Optional forced release of long grants when BUS_ARB_TIMEOUT_EN is defined.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ARB_IDLE  | no select asserted; arbitrates REQ starting at ptr
// ARB_GRANT | one select asserted; held until owner drops REQ (or timeout)
module bus_arbiter4_16
  import nicnac16_bus_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] REQ,
  output logic       SEL_A,
  output logic       SEL_B,
  output logic       SEL_C,
  output logic       SEL_D,
  output logic [1:0] OWNER,
  output logic       BUSY,
  output logic       TIMEOUT
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255 || CNT_W < $clog2(MAX_HOLD)) begin : g_param_err
    $error("bus_arbiter4_16: MAX_HOLD must be 2..255 and fit in CNT_W bits as MAX_HOLD-1");
  end

  arb_state_e state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] owner_q, owner_d;
  logic [3:0] sel_q, sel_d;
  logic       timeout_q, timeout_d;
  logic       release_grant;
  logic       pick_valid;
  logic [1:0] pick_idx;

  rr_pick4 u_pick (
    .req   (REQ),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

`ifdef BUS_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD - 1);
  logic [CNT_W-1:0] hold_q, hold_d;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ARB_IDLE;
      ptr_q     <= 2'd0;
      owner_q   <= 2'd0;
      sel_q     <= 4'b0000;
      timeout_q <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      sel_q     <= sel_d;
      timeout_q <= timeout_d;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_q    <= hold_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    sel_d         = sel_q;
    timeout_d     = 1'b0;
    release_grant = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
    hold_d        = hold_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d = ARB_GRANT;
          owner_d = pick_idx;
          sel_d   = onehot4(pick_idx);
`ifdef BUS_ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      ARB_GRANT: begin
        if (!REQ[owner_q]) begin
          release_grant = 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
        // Owner's own drop takes precedence, so a coincident timeout stays silent.
        end else if (hold_q == HOLD_MAX && (REQ & ~onehot4(owner_q)) != 4'b0000) begin
          release_grant = 1'b1;
          timeout_d     = 1'b1;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + 1'b1;
`endif
        end
        if (release_grant) begin
          state_d = ARB_IDLE;
          ptr_d   = owner_q + 2'd1;
          owner_d = 2'd0;
          sel_d   = 4'b0000;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign SEL_A   = sel_q[REQ_A];
  assign SEL_B   = sel_q[REQ_B];
  assign SEL_C   = sel_q[REQ_C];
  assign SEL_D   = sel_q[REQ_D];
  assign OWNER   = owner_q;
  assign BUSY    = (state_q == ARB_GRANT);
  assign TIMEOUT = timeout_q;

endmodule

// File: tb/tb_bus_arbiter4_16.sv
// Self-checking bench for bus_arbiter4_16: directed vector table, hand-written
// corner sequences, then random requests against a behavioural model.
module tb_bus_arbiter4_16;

  localparam int TB_MAX_HOLD = 4;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] REQ = 4'b0000;
  logic       SEL_A, SEL_B, SEL_C, SEL_D;
  logic [1:0] OWNER;
  logic       BUSY, TIMEOUT;

  int checks = 0;
  int errors = 0;

  bus_arbiter4_16 #(.MAX_HOLD(TB_MAX_HOLD), .CNT_W(8)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .REQ     (REQ),
    .SEL_A   (SEL_A),
    .SEL_B   (SEL_B),
    .SEL_C   (SEL_C),
    .SEL_D   (SEL_D),
    .OWNER   (OWNER),
    .BUSY    (BUSY),
    .TIMEOUT (TIMEOUT)
  );

  always #5 CLK = ~CLK;

  // Structural invariants every cycle.
  always @(negedge CLK) begin
    checks++;
    if (!$onehot0({SEL_D, SEL_C, SEL_B, SEL_A}) || BUSY !== |{SEL_D, SEL_C, SEL_B, SEL_A}) begin
      errors++;
      $display("FAIL invariant: sel=%b busy=%b, required one-hot-or-zero sel and busy==|sel",
               {SEL_D, SEL_C, SEL_B, SEL_A}, BUSY);
    end
  end

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] sel;
    logic [1:0] owner;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic [3:0] req, input logic [3:0] sel,
                              input logic [1:0] owner, input logic busy);
    vec_t v;
    v.rst = rst; v.req = req; v.sel = sel; v.owner = owner; v.busy = busy;
    vecs.push_back(v);
  endfunction

  task automatic step(input logic rst, input logic [3:0] req);
    RESET = rst;
    REQ   = req;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] es, input logic [1:0] eo,
                       input logic eb, input logic et);
    checks++;
    if ({SEL_D, SEL_C, SEL_B, SEL_A} !== es || OWNER !== eo || BUSY !== eb || TIMEOUT !== et) begin
      errors++;
      $display("FAIL %s: got sel=%b owner=%0d busy=%b timeout=%b, expected sel=%b owner=%0d busy=%b timeout=%b",
               name, {SEL_D, SEL_C, SEL_B, SEL_A}, OWNER, BUSY, TIMEOUT, es, eo, eb, et);
    end
  endtask

  // Behavioural model: integer owner/pointer bookkeeping.
  int m_busy, m_owner, m_ptr, m_hold, m_to;

  task automatic model_edge(input logic rst, input logic [3:0] req);
    bit rel;
    rel  = 0;
    m_to = 0;
    if (rst) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_hold = 0;
    end else if (m_busy == 0) begin
      for (int k = 0; k < 4; k++) begin
        if (m_busy == 0 && req[(m_ptr + k) % 4]) begin
          m_owner = (m_ptr + k) % 4;
          m_busy  = 1;
          m_hold  = 0;
        end
      end
    end else begin
      if (!req[m_owner]) rel = 1;
      else if (TO_EN && m_hold == TB_MAX_HOLD - 1 && (req & ~(4'b0001 << m_owner)) != 0) begin
        rel = 1; m_to = 1;
      end else if (m_hold < TB_MAX_HOLD - 1) m_hold++;
      if (rel) begin
        m_ptr = (m_owner + 1) % 4; m_owner = 0; m_busy = 0;
      end
    end
  endtask

  initial begin
    logic [3:0] rreq;
    logic       rrst;

    // Reset, full-load rotation, single requester, PTR wrap-around.
    add(1, 4'b1111, 4'b0000, 0, 0);
    add(1, 4'b1111, 4'b0000, 0, 0);
    add(0, 4'b1111, 4'b0001, 0, 1);
    add(0, 4'b1111, 4'b0001, 0, 1);
    add(0, 4'b1111, 4'b0001, 0, 1);
    add(0, 4'b1110, 4'b0000, 0, 0);
    add(0, 4'b1111, 4'b0010, 1, 1);
    add(0, 4'b1111, 4'b0010, 1, 1);
    add(0, 4'b1111, 4'b0010, 1, 1);
    add(0, 4'b1101, 4'b0000, 0, 0);
    add(0, 4'b1111, 4'b0100, 2, 1);
    add(0, 4'b1111, 4'b0100, 2, 1);
    add(0, 4'b1111, 4'b0100, 2, 1);
    add(0, 4'b1011, 4'b0000, 0, 0);
    add(0, 4'b1111, 4'b1000, 3, 1);
    add(0, 4'b1111, 4'b1000, 3, 1);
    add(0, 4'b1111, 4'b1000, 3, 1);
    add(0, 4'b0111, 4'b0000, 0, 0);
    add(0, 4'b1111, 4'b0001, 0, 1);
    add(0, 4'b1111, 4'b0001, 0, 1);
    add(0, 4'b1111, 4'b0001, 0, 1);
    add(0, 4'b1110, 4'b0000, 0, 0);
    add(0, 4'b0000, 4'b0000, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 4'b0100, 4'b0100, 2, 1);
    add(0, 4'b0000, 4'b0000, 0, 0);
    add(0, 4'b1001, 4'b1000, 3, 1);
    add(0, 4'b1001, 4'b1000, 3, 1);
    add(0, 4'b0001, 4'b0000, 0, 0);
    add(0, 4'b0001, 4'b0001, 0, 1);
    add(0, 4'b0000, 4'b0000, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].req);
      check($sformatf("vec%0d", i), vecs[i].sel, vecs[i].owner, vecs[i].busy, 1'b0);
    end

    // Reset during a C grant, then re-grant once reset releases.
    step(0, 4'b0100); check("rst_c_grant", 4'b0100, 2, 1, 0);
    step(0, 4'b0100); check("rst_c_hold", 4'b0100, 2, 1, 0);
    step(1, 4'b0100); check("rst_c_drop", 4'b0000, 0, 0, 0);
    step(0, 4'b0100); check("rst_c_regrant", 4'b0100, 2, 1, 0);
    step(0, 4'b0000); check("rst_c_release", 4'b0000, 0, 0, 0);

`ifdef BUS_ARB_TIMEOUT_EN
    // B hogs the bus while A waits: forced release after MAX_HOLD cycles.
    step(1, 4'b0000);
    step(0, 4'b0010); check("to_b_grant", 4'b0010, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 4'b0011); check($sformatf("to_b_hold%0d", i), 4'b0010, 1, 1, 0);
    end
    step(0, 4'b0011); check("to_fire", 4'b0000, 0, 0, 1);
    step(0, 4'b0011); check("to_a_grant", 4'b0001, 0, 1, 0);
    step(0, 4'b0000); check("to_a_release", 4'b0000, 0, 0, 0);
    // Owner drops exactly when the timeout would fire: plain release.
    step(1, 4'b0000);
    step(0, 4'b0010); check("to_coinc_grant", 4'b0010, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 4'b0011);
    step(0, 4'b0001); check("to_coinc_release", 4'b0000, 0, 0, 0);
    step(0, 4'b0001); check("to_coinc_next", 4'b0001, 0, 1, 0);
`endif

    // Random traffic against the model.
    step(1, 4'b0000);
    model_edge(1, 4'b0000);
    rreq = 4'b0000;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) rreq = 4'($urandom_range(0, 15));
      rrst = ($urandom_range(0, 63) == 0);
      step(rrst, rreq);
      model_edge(rrst, rreq);
      check($sformatf("rand%0d", i), m_busy != 0 ? (4'b0001 << m_owner) : 4'b0000,
            2'(m_owner), m_busy != 0, m_to != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
